note_synth: RTL and testbench
=============================

Name: note_synth

Overview:
- Two-voice square-wave tone generator, directly downstream of the win-animation / melody sequencers.
- Consumes the pair of 4-bit note codes (sound1, sound2) and produces audio for the board speaker.
- Outputs both a 2-bit summed level (for a resistor DAC) and a 1-bit first-order delta-sigma stream (for a single speaker pin).

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz; used at elaboration to build the half-period table.
- CNT_W, 18, half-period counter width; must hold the largest table entry (113636 at 50 MHz).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = play, 0 = mute both voices.
- sound1  input  4  note code for voice 1.
- sound2  input  4  note code for voice 2.
- audio_level  output  2  ph1 + ph2, range 0..2.
- pdm_out  output  1  delta-sigma encoding of audio_level (full scale = 2).

Behaviour:
- Note codes 0..14 = A major scale, A3 (220 Hz) to A5 (880 Hz), in centihertz: 22000, 24694, 27718, 29366, 32963, 36999, 41530, 44000, 49388, 55437, 58733, 65926, 73999, 83061, 88000.
- Code 15 = rest (silence).
- Half-period for code n: HALF[n] = floor(CLK_HZ*50 / cHz[n]), computed in 64-bit elaboration arithmetic. Each entry must be >= 2 (elaboration assertion).
- Input stage: sound1, sound2 and enable are registered once on posedge clk, because the upstream sequencer updates them combinationally off its negedge state. All voice logic uses the registered copies (n1, n2, en_q). Latency from input change to voice reaction: 1 cycle.
- Per voice (identical logic, x = 1, 2), state is cnt[CNT_W-1:0], ph, and last code lc[3:0]:
  - reset: cnt = 0, ph = 0, lc = 15.
  - Muted (en_q = 0 or nx = 15): ph = 0, cnt = 0, lc = nx.
  - Code change (nx != lc, not muted): lc = nx, cnt = HALF[nx]-1, ph = 0. The phase restarts cleanly; the click is accepted.
  - Running (nx == lc): if cnt == 0 then ph toggles and cnt = HALF[nx]-1, else cnt decrements.
  - Result: the first ph edge occurs HALF cycles after the code-change cycle; ph period = 2*HALF cycles.
- audio_level is registered: audio_level = ph1 + ph2, one cycle after the phases.
- pdm_out, with 2-bit accumulator acc:
  - s = acc + audio_level.
  - If s >= 2: pdm_out = 1 and acc = s-2; otherwise pdm_out = 0 and acc = s.
  - Registered. Reset: acc = 0, pdm_out = 0.
  - Level 0 gives constant 0, level 1 gives alternating 0/1, level 2 gives constant 1.
- Reset values of all outputs: audio_level = 0, pdm_out = 0.
- Reset mid-note: all state is cleared next edge. After reset deasserts, the first playing code is treated as a code change.
- Both voices on the same code: identical phases, so audio_level toggles 0/2.
- enable dropping mid-period: ph forced to 0 the next cycle. When enable re-asserts, lc still equals nx, so the voice resumes with cnt = 0, and ph toggles on the first running cycle.

Decomposition:
- Shared package synth_pkg:
  - NOTE_REST = 4'd15.
  - Centihertz frequency table (15 entries).
  - Function computing HALF[n] from CLK_HZ.
  - The note-code constants (A, B, C_s … A3) already used by the sequencers, so upstream and downstream share a single definition.
- One sub-module: tone_voice (registered code in, en, ph out, counter and lc inside), instantiated twice. Mixer and delta-sigma stay in note_synth.

Test Plan (CLK_HZ = 8800, giving HALF[0] = 20, HALF[4] = 13, HALF[7] = 10, HALF[14] = 5):
- Reset held 3 cycles with sound1 = 0, enable = 1 -> audio_level = 0, pdm_out = 0 throughout. After release, the first ph1 rise is 20 cycles after the registered code change, then ph1 toggles every 20 cycles.
- sound1 = 0, sound2 = 15, enable = 1 -> audio_level alternates 0/1 in 20-cycle runs. pdm_out is 0 while level = 0 and alternates 0,1,0,1 while level = 1.
- sound1 = 14, sound2 = 14 -> audio_level alternates 0 and 2 every 5 cycles. pdm_out is constant 1 during level-2 runs and 0 otherwise.
- sound1 changes 7 -> 4 mid-period -> ph1 = 0 on the cycle after the registered change, then the first rise 13 cycles later. Voice 2 is unaffected.
- sound1 = 7, enable dropped for 4 cycles then raised -> ph1 and audio_level are 0 from 1 cycle after the drop. ph1 resumes toggling immediately on re-enable, then every 10 cycles.
- Reset asserted while both voices play -> next edge: audio_level = 0, pdm_out = 0, acc = 0. Playback restarts from code-change timing after release.

Source files
------------

// File: rtl/synth_pkg.sv
// Note codes and tone tables shared by the melody sequencers and the tone generator.
package synth_pkg;

    localparam logic [3:0] NOTE_A3   = 4'd0;
    localparam logic [3:0] NOTE_B3   = 4'd1;
    localparam logic [3:0] NOTE_C_S4 = 4'd2;
    localparam logic [3:0] NOTE_D4   = 4'd3;
    localparam logic [3:0] NOTE_E4   = 4'd4;
    localparam logic [3:0] NOTE_F_S4 = 4'd5;
    localparam logic [3:0] NOTE_G_S4 = 4'd6;
    localparam logic [3:0] NOTE_A4   = 4'd7;
    localparam logic [3:0] NOTE_B4   = 4'd8;
    localparam logic [3:0] NOTE_C_S5 = 4'd9;
    localparam logic [3:0] NOTE_D5   = 4'd10;
    localparam logic [3:0] NOTE_E5   = 4'd11;
    localparam logic [3:0] NOTE_F_S5 = 4'd12;
    localparam logic [3:0] NOTE_G_S5 = 4'd13;
    localparam logic [3:0] NOTE_A5   = 4'd14;
    localparam logic [3:0] NOTE_REST = 4'd15;

    // A major scale, A3..A5, in centihertz; rest maps to 0.
    function automatic longint unsigned note_chz(input logic [3:0] n);
        case (n)
            4'd0:    return 64'd22000;
            4'd1:    return 64'd24694;
            4'd2:    return 64'd27718;
            4'd3:    return 64'd29366;
            4'd4:    return 64'd32963;
            4'd5:    return 64'd36999;
            4'd6:    return 64'd41530;
            4'd7:    return 64'd44000;
            4'd8:    return 64'd49388;
            4'd9:    return 64'd55437;
            4'd10:   return 64'd58733;
            4'd11:   return 64'd65926;
            4'd12:   return 64'd73999;
            4'd13:   return 64'd83061;
            4'd14:   return 64'd88000;
            default: return 64'd0;
        endcase
    endfunction

    // Half-period in clock cycles: clk_hz / (2 * Hz) = clk_hz * 50 / cHz.
    function automatic longint unsigned half_period(input longint unsigned clk_hz,
                                                    input logic [3:0] n);
        if (note_chz(n) == 64'd0) return 64'd0;
        return (clk_hz * 64'd50) / note_chz(n);
    endfunction

endpackage

// File: rtl/note_synth_tone_voice.sv
// One square-wave voice: half-period counter restarted on every note change.
module tone_voice
    import synth_pkg::*;
#(
    parameter longint unsigned CLK_HZ = 50000000,
    parameter int              CNT_W  = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] code,
    output logic       ph
);

    logic [CNT_W-1:0] reload_tab [16];

    for (genvar i = 0; i < 16; i++) begin : g_tab
        localparam longint unsigned HALF = half_period(CLK_HZ, 4'(i));
        if (i == int'(NOTE_REST)) begin : g_rest
            assign reload_tab[i] = '0;
        end else begin : g_note
            if (HALF < 64'd2 || HALF > (64'd1 << CNT_W)) begin : g_bad
                $error("tone_voice: half-period out of range for note %0d", i);
            end
            assign reload_tab[i] = CNT_W'(HALF - 64'd1);
        end
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ph_q, ph_d;
    logic [3:0]       lc_q, lc_d;

    always_comb begin
        cnt_d = cnt_q;
        ph_d  = ph_q;
        lc_d  = lc_q;
        if (!en || code == NOTE_REST) begin
            // lc keeps tracking the code so a re-enable on the same note resumes at once
            cnt_d = '0;
            ph_d  = 1'b0;
            lc_d  = code;
        end else if (code != lc_q) begin
            cnt_d = reload_tab[code];
            ph_d  = 1'b0;
            lc_d  = code;
        end else if (cnt_q == '0) begin
            cnt_d = reload_tab[code];
            ph_d  = ~ph_q;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
            lc_q  <= NOTE_REST;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
            lc_q  <= lc_d;
        end
    end

    assign ph = ph_q;

endmodule

// File: rtl/note_synth.sv
// Two-voice square-wave tone generator with 2-bit level and 1-bit delta-sigma outputs.
module note_synth
    import synth_pkg::*;
#(
    parameter longint unsigned CLK_HZ = 50000000,
    parameter int              CNT_W  = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] sound1,
    input  logic [3:0] sound2,
    output logic [1:0] audio_level,
    output logic       pdm_out
);

    localparam int NUM_VOICES = 2;

    // Inputs change off the sequencer's negedge, so capture them once here.
    logic [NUM_VOICES-1:0][3:0] n_q, n_d;
    logic                       en_q, en_d;
    logic [NUM_VOICES-1:0]      ph;
    logic [1:0]                 lvl_q, lvl_d;
    logic [1:0]                 acc_q, acc_d;
    logic                       pdm_q, pdm_d;
    logic [2:0]                 sum;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        tone_voice #(
            .CLK_HZ(CLK_HZ),
            .CNT_W (CNT_W)
        ) u_voice (
            .clk  (clk),
            .reset(reset),
            .en   (en_q),
            .code (n_q[v]),
            .ph   (ph[v])
        );
    end

    always_comb begin
        n_d   = {sound2, sound1};
        en_d  = enable;
        lvl_d = {1'b0, ph[0]} + {1'b0, ph[1]};
        sum   = {1'b0, acc_q} + {1'b0, lvl_q};
        pdm_d = 1'b0;
        acc_d = sum[1:0];
        if (sum >= 3'd2) begin
            pdm_d = 1'b1;
            acc_d = 2'(sum - 3'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q   <= {NOTE_REST, NOTE_REST};
            en_q  <= 1'b0;
            lvl_q <= 2'd0;
            acc_q <= 2'd0;
            pdm_q <= 1'b0;
        end else begin
            n_q   <= n_d;
            en_q  <= en_d;
            lvl_q <= lvl_d;
            acc_q <= acc_d;
            pdm_q <= pdm_d;
        end
    end

    assign audio_level = lvl_q;
    assign pdm_out     = pdm_q;

endmodule

// File: tb/tb_note_synth.sv
// Randomized scoreboard bench for note_synth against a time-based phase model.
module tb_note_synth;

    localparam longint unsigned CLK_HZ = 8800;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] sound1 = 4'd0;
    logic [3:0] sound2 = 4'd15;
    logic [1:0] audio_level;
    logic       pdm_out;

    always #5 clk = ~clk;

    note_synth #(.CLK_HZ(CLK_HZ), .CNT_W(18)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sound1     (sound1),
        .sound2     (sound2),
        .audio_level(audio_level),
        .pdm_out    (pdm_out)
    );

    typedef struct packed {
        logic [1:0] lvl;
        logic       pdm;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    longint unsigned chz [15] = '{22000, 24694, 27718, 29366, 32963, 36999, 41530, 44000,
                                  49388, 55437, 58733, 65926, 73999, 83061, 88000};

    function automatic int half_of(input int n);
        return int'((CLK_HZ * 50) / chz[n]);
    endfunction

    // Model: a playing voice's phase is a function of time since its start point t0.
    int m_t;
    int m_n  [2];
    bit m_en;
    int m_lc [2];
    int m_t0 [2];
    bit m_wm [2];
    bit m_ph [2];
    int m_lvl;
    int m_acc;
    bit m_pdm;

    function automatic void model_step(input bit r, input int a, input int b, input bit e);
        int s;
        m_t++;
        if (r) begin
            for (int v = 0; v < 2; v++) begin
                m_lc[v] = 15; m_ph[v] = 1'b0; m_wm[v] = 1'b1; m_t0[v] = 0;
            end
            m_lvl = 0; m_acc = 0; m_pdm = 1'b0;
        end else begin
            s     = m_acc + m_lvl;
            m_pdm = (s >= 2);
            m_acc = m_pdm ? s - 2 : s;
            m_lvl = int'(m_ph[0]) + int'(m_ph[1]);
            for (int v = 0; v < 2; v++) begin
                if (!m_en || m_n[v] == 15) begin
                    m_ph[v] = 1'b0; m_lc[v] = m_n[v]; m_wm[v] = 1'b1;
                end else begin
                    if (m_n[v] != m_lc[v]) begin
                        m_lc[v] = m_n[v]; m_t0[v] = m_t;
                    end else if (m_wm[v]) begin
                        m_t0[v] = m_t - half_of(m_n[v]);
                    end
                    m_wm[v] = 1'b0;
                    m_ph[v] = (((m_t - m_t0[v]) / half_of(m_n[v])) % 2) == 1;
                end
            end
        end
        m_n[0] = r ? 15 : a;
        m_n[1] = r ? 15 : b;
        m_en   = r ? 1'b0 : e;
    endfunction

    task automatic cycle(input bit r, input int a, input int b, input bit e);
        exp_t x;
        @(negedge clk);
        reset  = r;
        sound1 = 4'(a);
        sound2 = 4'(b);
        enable = e;
        model_step(r, a, b, e);
        x.lvl = 2'(m_lvl);
        x.pdm = m_pdm;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (audio_level !== x.lvl || pdm_out !== x.pdm) begin
                    failures++;
                    $display("FAIL outputs t=%0t level=%0d pdm=%0b expected level=%0d pdm=%0b",
                             $time, audio_level, pdm_out, x.lvl, x.pdm);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int len, a, b;
        bit e, r;
        m_t = 0; m_en = 1'b0; m_lvl = 0; m_acc = 0; m_pdm = 1'b0;
        for (int v = 0; v < 2; v++) begin
            m_n[v] = 15; m_lc[v] = 15; m_t0[v] = 0; m_wm[v] = 1'b1; m_ph[v] = 1'b0;
        end
        repeat (3)  cycle(1, 0, 15, 1);
        repeat (90) cycle(0, 0, 15, 1);
        repeat (30) cycle(0, 14, 14, 1);
        repeat (25) cycle(0, 7, 0, 1);
        repeat (35) cycle(0, 4, 0, 1);
        repeat (15) cycle(0, 7, 15, 1);
        repeat (4)  cycle(0, 7, 15, 0);
        repeat (30) cycle(0, 7, 15, 1);
        repeat (20) cycle(0, 14, 7, 1);
        repeat (2)  cycle(1, 14, 7, 1);
        repeat (40) cycle(0, 14, 7, 1);
        repeat (120) begin
            len = $urandom_range(1, 40);
            a   = $urandom_range(0, 15);
            b   = $urandom_range(0, 15);
            e   = ($urandom_range(0, 7) != 0);
            r   = ($urandom_range(0, 24) == 0);
            repeat (len) cycle(r, a, b, e);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
